// File: rtl/mux_rr_sel.sv
// N-channel registered selector with valid/ready handshakes, fixed-select and round-robin modes.
// Optional saturating output-transfer counter on xfer_cnt when MUX_XFER_CNT_EN is defined.
module mux_rr_sel #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   localparam int SELW = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
`ifdef MUX_XFER_CNT_EN
   output logic [15:0]          xfer_cnt,
`endif
   output logic [SELW-1:0]      out_ch
);

   logic [WIDTH-1:0] out_data_r;
   logic             out_valid_r;
   logic [SELW-1:0]  out_ch_r;
   logic [SELW-1:0]  last_grant_r;

   logic             load_en_s;
   logic             grant_valid_s;
   logic [SELW-1:0]  grant_s;
   logic [SELW-1:0]  cand_s;
   logic [NCH-1:0]   in_ready_s;
   logic [WIDTH-1:0] sel_data_s;
   logic             in_xfer_s;
   logic             out_xfer_s;

   // Grant decision: fixed select or round-robin search starting after the last RR grant.
   always_comb begin
      load_en_s     = !out_valid_r || out_ready;
      grant_valid_s = 1'b0;
      grant_s       = '0;
      cand_s        = '0;
      if (mode == 1'b0) begin
         if ({1'b0, sel} < (SELW+1)'(NCH)) begin
            if (in_valid[sel]) begin
               grant_valid_s = 1'b1;
               grant_s       = sel;
            end else begin
               grant_valid_s = 1'b0;
            end
         end else begin
            grant_valid_s = 1'b0;
         end
      end else begin
         for (int k = 1; k <= NCH; k++) begin
            cand_s = SELW'((int'(last_grant_r) + k) % NCH);
            if (!grant_valid_s && in_valid[cand_s]) begin
               grant_valid_s = 1'b1;
               grant_s       = cand_s;
            end else begin
               grant_valid_s = grant_valid_s;
            end
         end
      end
   end

   // Handshake decode and data steering for the granted channel.
   always_comb begin
      in_ready_s = '0;
      if (rst_n && load_en_s && grant_valid_s) begin
         in_ready_s[grant_s] = 1'b1;
      end else begin
         in_ready_s = '0;
      end
      sel_data_s = in_data[int'(grant_s)*WIDTH +: WIDTH];
      in_xfer_s  = rst_n && load_en_s && grant_valid_s;
      out_xfer_s = out_valid_r && out_ready;
   end

   // One-entry output register; a simultaneous drain and load overwrites without a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_r   <= '0;
         out_valid_r  <= 1'b0;
         out_ch_r     <= '0;
         last_grant_r <= SELW'(NCH-1);
      end else if (in_xfer_s) begin
         out_data_r  <= sel_data_s;
         out_ch_r    <= grant_s;
         out_valid_r <= 1'b1;
         if (mode) begin
            last_grant_r <= grant_s;
         end
      end else if (out_xfer_s) begin
         out_valid_r <= 1'b0;
      end
   end

`ifdef MUX_XFER_CNT_EN
   logic [15:0] xfer_cnt_r;

   // Saturating count of words taken by the consumer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt_r <= 16'd0;
      end else if (out_xfer_s && (xfer_cnt_r != 16'hFFFF)) begin
         xfer_cnt_r <= xfer_cnt_r + 16'd1;
      end
   end

   assign xfer_cnt = xfer_cnt_r;
`endif

   assign in_ready  = in_ready_s;
   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
   assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_mux_rr_sel.sv
// Self-checking bench for mux_rr_sel: vector table plus scoreboard, reset and counter sequences.
module tb_mux_rr_sel;

   localparam int WIDTH = 8;
   localparam int NCH   = 4;
   localparam int SELW  = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NCH*WIDTH-1:0] in_data = '0;
   logic [NCH-1:0]       in_valid = '0;
   logic [NCH-1:0]       in_ready;
   logic                 mode = 1'b0;
   logic [SELW-1:0]      sel = '0;
   logic [WIDTH-1:0]     out_data;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [SELW-1:0]      out_ch;
`ifdef MUX_XFER_CNT_EN
   logic [15:0]          xfer_cnt;
`endif

   mux_rr_sel #(.WIDTH(WIDTH), .NCH(NCH)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready),
`ifdef MUX_XFER_CNT_EN
      .xfer_cnt(xfer_cnt),
`endif
      .out_ch(out_ch)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic                 mode;
      logic [SELW-1:0]      sel;
      logic [NCH-1:0]       vld;
      logic [NCH*WIDTH-1:0] din;
      logic                 rdy;
      logic [NCH-1:0]       exp_rdy;
   } vec_t;

   typedef struct {
      logic [SELW-1:0]  ch;
      logic [WIDTH-1:0] data;
   } word_t;

   int    n_chk  = 0;
   int    n_fail = 0;
   word_t sb[$];
   vec_t  vecs[18];

   localparam logic [31:0] D_INC = 32'h13121110;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [SELW-1:0] onehot_idx(input logic [NCH-1:0] oh);
      logic [SELW-1:0] r;
      r = '0;
      for (int i = 0; i < NCH; i++) begin
         if (oh[i]) r = SELW'(i);
      end
      return r;
   endfunction

   // Drive one cycle, check in_ready, then update and check the scoreboard after the edge.
   task automatic step(input vec_t v);
      bit    exp_out_xfer;
      word_t w;
      mode = v.mode; sel = v.sel; in_valid = v.vld; in_data = v.din; out_ready = v.rdy;
      #1;
      chk("in_ready", 32'(in_ready), 32'(v.exp_rdy));
      exp_out_xfer = (sb.size() > 0) && v.rdy;
      @(posedge clk);
      if (exp_out_xfer) void'(sb.pop_front());
      if (v.exp_rdy != '0) begin
         w.ch   = onehot_idx(v.exp_rdy);
         w.data = v.din[int'(w.ch)*WIDTH +: WIDTH];
         sb.push_back(w);
      end
      #1;
      chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
      if (sb.size() > 0) begin
         chk("out_data", 32'(out_data), 32'(sb[0].data));
         chk("out_ch", 32'(out_ch), 32'(sb[0].ch));
      end
   endtask

   function automatic vec_t mk(input logic m, input logic [SELW-1:0] s, input logic [NCH-1:0] vl,
                               input logic [31:0] d, input logic r, input logic [NCH-1:0] e);
      vec_t v;
      v.mode = m; v.sel = s; v.vld = vl; v.din = d; v.rdy = r; v.exp_rdy = e;
      return v;
   endfunction

   initial begin
      // Fixed select, RR fairness, backpressure, invalid fixed target, idle, held word.
      vecs[0]  = mk(1'b0, 2'd2, 4'b0100, 32'h13A51110, 1'b1, 4'b0100);
      vecs[1]  = mk(1'b1, 2'd0, 4'b1111, D_INC,        1'b1, 4'b0001);
      vecs[2]  = mk(1'b1, 2'd0, 4'b1111, D_INC,        1'b1, 4'b0010);
      vecs[3]  = mk(1'b1, 2'd0, 4'b1111, D_INC,        1'b1, 4'b0100);
      vecs[4]  = mk(1'b1, 2'd0, 4'b1111, D_INC,        1'b1, 4'b1000);
      vecs[5]  = mk(1'b1, 2'd0, 4'b1111, D_INC,        1'b1, 4'b0001);
      vecs[6]  = mk(1'b1, 2'd0, 4'b1111, D_INC,        1'b1, 4'b0010);
      vecs[7]  = mk(1'b0, 2'd3, 4'b1000, 32'h3C121110, 1'b1, 4'b1000);
      vecs[8]  = mk(1'b1, 2'd0, 4'b1111, D_INC,        1'b0, 4'b0000);
      vecs[9]  = mk(1'b1, 2'd0, 4'b1111, D_INC,        1'b0, 4'b0000);
      vecs[10] = mk(1'b1, 2'd0, 4'b1111, D_INC,        1'b0, 4'b0000);
      vecs[11] = mk(1'b1, 2'd0, 4'b1111, D_INC,        1'b1, 4'b0100);
      vecs[12] = mk(1'b0, 2'd2, 4'b1011, D_INC,        1'b1, 4'b0000);
      vecs[13] = mk(1'b0, 2'd2, 4'b1011, D_INC,        1'b1, 4'b0000);
      vecs[14] = mk(1'b0, 2'd3, 4'b1011, D_INC,        1'b1, 4'b1000);
      vecs[15] = mk(1'b1, 2'd0, 4'b0000, D_INC,        1'b1, 4'b0000);
      vecs[16] = mk(1'b1, 2'd0, 4'b1010, D_INC,        1'b0, 4'b1000);
      vecs[17] = mk(1'b1, 2'd0, 4'b1010, D_INC,        1'b0, 4'b0000);

      // Reset state, with inputs active to show in_ready is gated.
      in_valid = 4'b1111; out_ready = 1'b1;
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_ch", 32'(out_ch), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 18; i++) step(vecs[i]);

      // Async reset while a word is held under backpressure.
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data", 32'(out_data), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      sb.delete();
      #4;
      rst_n = 1'b1;
      #1;
      step(mk(1'b1, 2'd0, 4'b1111, D_INC, 1'b1, 4'b0001));
      step(mk(1'b1, 2'd0, 4'b1111, D_INC, 1'b1, 4'b0010));
      step(mk(1'b1, 2'd0, 4'b0000, D_INC, 1'b1, 4'b0000));

`ifdef MUX_XFER_CNT_EN
      rst_n = 1'b0;
      #2;
      chk("cnt_rst", 32'(xfer_cnt), 32'd0);
      rst_n = 1'b1;
      sb.delete();
      #1;
      for (int i = 0; i < 5; i++) step(mk(1'b0, 2'd0, 4'b0001, D_INC, 1'b1, 4'b0001));
      step(mk(1'b0, 2'd0, 4'b0000, D_INC, 1'b1, 4'b0000));
      step(mk(1'b0, 2'd0, 4'b0000, D_INC, 1'b0, 4'b0000));
      step(mk(1'b0, 2'd0, 4'b0000, D_INC, 1'b0, 4'b0000));
      chk("cnt_five", 32'(xfer_cnt), 32'd5);
      in_valid = 4'b0001; out_ready = 1'b1;
      for (int i = 0; i < 65540; i++) @(posedge clk);
      #1;
      chk("cnt_sat", 32'(xfer_cnt), 32'h0000FFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_rr_sel.md
# mux_rr_sel

Parametrised N-channel, WIDTH-bit registered selector, the successor to the combinational per-bit 2:1 data muxes used on the multiplier datapath. It adds per-channel valid/ready handshakes, a one-entry output register, and two runtime modes: fixed select and round-robin arbitration. It sits between multiple operand/result producers and a single downstream consumer, for example the multiplier operand port or the result writeback.

## Interface
- WIDTH, 8, data width per channel.
- NCH, 4, number of input channels, minimum 2.
- SELW, derived localparam = $clog2(NCH), width of select and channel tag.

Reset is asynchronous and active-low; there is one clock.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NCH  per-channel valid.
- in_ready  out  NCH  per-channel ready; at most one bit is high per cycle.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SELW  channel index used in fixed mode.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.
- out_ch  out  SELW  index of the channel that sourced out_data.
- xfer_cnt  out  16  present only with MUX_XFER_CNT_EN.

## Operation
- load_en = !out_valid || out_ready. The output register can accept a new word when it is empty or is being drained in the same cycle.
- Fixed mode: the candidate channel is sel. A grant is issued only if in_valid[sel] is high. If sel >= NCH, no grant is issued and no in_ready is asserted.
- Round-robin mode: the candidate is the first i with in_valid[i] high, searching from last_grant+1 upward and wrapping modulo NCH. If no channel is valid, there is no grant.
- in_ready[g] = load_en && grant_valid for the granted channel g only. All other in_ready bits are 0.
- Input transfer occurs when in_valid[g] && in_ready[g]. On that edge:
  - out_data <= channel g data
  - out_ch <= g
  - out_valid <= 1
  - in RR mode only, last_grant <= g.
- Output transfer occurs when out_valid && out_ready. If no input transfer happens in the same cycle, out_valid <= 0 and out_data/out_ch hold their values.
- Simultaneous input and output transfer: the register is overwritten with the new word and out_valid stays 1. This gives full throughput with no bubble.
- When out_valid=1 and out_ready=0, the register and out_ch are held stable and all in_ready bits are 0.
- mode and sel are sampled combinationally each cycle. A change takes effect on the next grant decision and never corrupts a held word.
- last_grant is not updated in fixed mode. Switching back to RR resumes from the last RR grant.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, last_grant=NCH-1 (so the first RR search starts at channel 0), xfer_cnt=0.
- Reset mid-operation clears the held word immediately and asynchronously. in_ready is 0 while rst_n is low.
- Latency is 1 cycle from input handshake to out_valid.
- Throughput is 1 word per cycle while out_ready is held high.
- in_ready depends combinationally on in_valid, mode, sel and out_ready. out_* are pure register outputs.
- Fairness: in RR mode with all channels valid and out_ready=1, grants cycle 0,1,...,NCH-1,0 with no channel skipped.

## Configuration
- MUX_XFER_CNT_EN defined: the xfer_cnt port exists. It is a 16-bit count of output transfers (out_valid && out_ready) that saturates at 16'hFFFF and resets to 0.
- MUX_XFER_CNT_EN undefined: the port and the counter logic are absent, and all other behaviour is identical.

## Test plan
- Reset, then WIDTH=8, NCH=4, mode=0, sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=8'hA5, out_ch=2.
- mode=1, all in_valid=1, ch i data=8'h10+i, out_ready=1 for 6 cycles -> out_ch sequence 0,1,2,3,0,1 with matching data and out_valid continuously 1.
- Backpressure: word 8'h3C held, out_ready=0 for 3 cycles while inputs are valid -> out_data stays 8'h3C, in_ready=0. On release, the next word appears one cycle later.
- Fixed mode with sel=2, in_valid=4'b1011 -> no grant and out_valid stays 0. Then sel=3 -> in_ready=4'b1000.
- rst_n pulsed low while out_valid=1 and out_ready=0 -> out_valid=0, out_data=0 immediately. After release, the RR grant starts at channel 0.
- With MUX_XFER_CNT_EN, 5 output transfers followed by 2 held cycles -> xfer_cnt=5. Forcing 65540 transfers -> xfer_cnt=16'hFFFF.
